mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 mux output channel among 8 requesters.
- Each requester i owns mux input in[i]. The arbiter grants one requester at a time, drives the mux select, and registers the selected bit onto a single output with a valid flag.
- A hold limit bounds how long any one requester keeps the channel, which prevents starvation.
- Sits directly in front of the 8:1 mux datapath and replaces a free-running select counter.

---
 rtl/mux8_rr_arbiter_if.sv | 44 ++++
 rtl/mux8_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_if
// Bundles the request/data side and the grant/output side of the 8:1 mux
// arbiter into a single port.
//   req       : request vector, bit i = requester i wants the channel
//   in        : mux data inputs, in[i] belongs to requester i
//   gnt       : one-hot grant (zero when idle)
//   sel       : mux select, index of the granted requester
//   busy      : high while a grant is active
//   out       : registered mux output
//   out_valid : qualifies out
// Modports:
//   master : requester / datapath side (drives req and in)
//   slave  : arbiter side (drives gnt, sel, busy, out, out_valid)
// ---------------------------------------------------------------------------
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       out;
  logic       out_valid;

  modport master (
    output req,
    output in,
    input  gnt,
    input  sel,
    input  busy,
    input  out,
    input  out_valid
  );

  modport slave (
    input  req,
    input  in,
    output gnt,
    output sel,
    output busy,
    output out,
    output out_valid
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing one 8:1 mux output channel among 8 requesters.
// A grant lasts at most MAX_HOLD cycles, ends early when the owner drops its
// request, and is always followed by one idle bubble before re-arbitration.
// The selected mux input is registered onto out one cycle after the grant.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux8_rr_arbiter_if.slave (req, in, gnt, sel, busy, out, out_valid)
//
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles (1..15)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
//
// Build option:
//   MUX8_ARB_FIXED_PRIO_EN : when defined, the lowest-index request always
//   wins and the round-robin pointer is removed; hold limit and bubble are
//   unchanged.
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux8_rr_arbiter_if.slave       bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             out_q, out_valid_q;

  logic             busy;
  logic             release_now;
  logic [2:0]       scan_base;
  logic [2:0]       winner;

  assign busy = (state_q == GRANT);

  // Owner dropped its request or has used up its hold budget.
  assign release_now = busy && (!bus.req[sel_q] || (cnt_q == MAX_HOLD_C));

`ifdef MUX8_ARB_FIXED_PRIO_EN
  // Fixed priority: the scan always starts at index 0.
  assign scan_base = 3'd0;
`else
  logic [2:0] ptr_q, ptr_d;

  assign scan_base = ptr_q;

  // Next scan starts just past the requester that was released; the 3-bit
  // add wraps 7 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (release_now) begin
      ptr_d = sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Scan from the highest offset down so the last hit is the requester
  // closest to scan_base.
  always_comb begin
    logic [2:0] cand;
    winner = 3'd0;
    cand   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = scan_base + 3'(k);
      if (bus.req[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (|bus.req) begin
          gnt_d   = 8'h01 << winner;
          sel_d   = winner;
          cnt_d   = CNT_ONE;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // sel keeps its last value through the bubble.
          gnt_d   = 8'h00;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        gnt_d   = 8'h00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  // Output stage lags the grant by one cycle; in is only looked at while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= busy;
      out_q       <= busy ? bus.in[sel_q] : 1'b0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
// Scenario tasks push the expected per-cycle {gnt, sel, busy, out_valid, out}
// into a queue, then pop one entry per clock and compare against the DUT.
// Build with +define+MUX8_ARB_FIXED_PRIO_EN to check the fixed-priority build.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out_valid;
    logic       out;
  } exp_t;

  logic clk;
  logic rst_n;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] in_val;
  logic [7:0] prev_g;
  logic [2:0] last_sel;
  int         checks;
  int         fails;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Expected outputs for the cycle in which gnt == g; out/out_valid reflect
  // the previous cycle's grant.
  task automatic push(input logic [7:0] g);
    exp_t e;
    if (g != 8'h00) last_sel = idx_of(g);
    e.gnt       = g;
    e.sel       = last_sel;
    e.busy      = (g != 8'h00);
    e.out_valid = (prev_g != 8'h00);
    e.out       = (prev_g != 8'h00) ? in_val[idx_of(prev_g)] : 1'b0;
    exp_q.push_back(e);
    prev_g = g;
  endtask

  task automatic push_grant(input int idx, input int n);
    logic [7:0] g;
    g = 8'h01 << idx;
    for (int i = 0; i < n; i++) push(g);
  endtask

  task automatic do_reset();
    bus.req = 8'h00;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_q.delete();
    prev_g   = 8'h00;
    last_sel = 3'd0;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t obs;
    int   c;
    do_reset();
    obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
    checks++;
    if (obs !== 14'd0) begin
      fails++;
      $display("FAIL reset_init: got %b exp %b", obs, 14'd0);
    end else $display("reset_init state=%b", obs);
    bus.req = 8'hFF;
    push_grant(0, 2);
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_pre c%0d: got %b exp %b", c, obs, e);
      end else $display("reset_pre c%0d gnt=%h sel=%0d ov=%b out=%b", c, obs.gnt, obs.sel, obs.out_valid, obs.out);
      c++;
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
    checks++;
    if (obs !== 14'd0) begin
      fails++;
      $display("FAIL reset_async: got %b exp %b", obs, 14'd0);
    end else $display("reset_async state=%b", obs);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_g   = 8'h00;
    last_sel = 3'd0;
    push_grant(0, 4);
    push(8'h00);
`ifdef MUX8_ARB_FIXED_PRIO_EN
    push_grant(0, 2);
`else
    push_grant(1, 2);
`endif
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_post c%0d: got %b exp %b", c, obs, e);
      end else $display("reset_post c%0d gnt=%h sel=%0d ov=%b out=%b", c, obs.gnt, obs.sel, obs.out_valid, obs.out);
      c++;
    end
  endtask

  task automatic test_single();
    exp_t e;
    exp_t obs;
    int   c;
    do_reset();
    bus.req = 8'b0000_0100;
    push_grant(2, 4);
    push(8'h00);
    push_grant(2, 4);
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL single c%0d: got %b exp %b", c, obs, e);
      end else $display("single c%0d gnt=%h sel=%0d ov=%b out=%b", c, obs.gnt, obs.sel, obs.out_valid, obs.out);
      c++;
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    exp_t obs;
    int   c;
    do_reset();
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
`ifdef MUX8_ARB_FIXED_PRIO_EN
      push_grant(0, 4);
`else
      push_grant(g % 8, 4);
`endif
      push(8'h00);
    end
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL round_robin c%0d: got %b exp %b", c, obs, e);
      end else $display("round_robin c%0d gnt=%h sel=%0d ov=%b out=%b", c, obs.gnt, obs.sel, obs.out_valid, obs.out);
      c++;
    end
  endtask

  task automatic test_early_release();
    exp_t e;
    exp_t obs;
    int   c;
    do_reset();
    bus.req = 8'b0010_0000;
    push_grant(5, 2);
    push(8'h00);
    push_grant(0, 4);
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL early_release c%0d: got %b exp %b", c, obs, e);
      end else $display("early_release c%0d gnt=%h sel=%0d ov=%b out=%b", c, obs.gnt, obs.sel, obs.out_valid, obs.out);
      if (c == 1) bus.req = 8'b0000_0001;
      if (c == 2) bus.req = 8'b0010_0001;
      c++;
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    exp_t obs;
    int   c;
    do_reset();
    bus.req = 8'h80;
    push_grant(7, 4);
    push(8'h00);
    push_grant(0, 4);
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {bus.gnt, bus.sel, bus.busy, bus.out_valid, bus.out};
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL wrap c%0d: got %b exp %b", c, obs, e);
      end else $display("wrap c%0d gnt=%h sel=%0d ov=%b out=%b", c, obs.gnt, obs.sel, obs.out_valid, obs.out);
      if (c == 0) bus.req = 8'h81;
      c++;
    end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_val   = 8'b1010_1010;
    bus.in   = in_val;
    bus.req  = 8'h00;
    prev_g   = 8'h00;
    last_sel = 3'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
